// File: rtl/dpram_pkg.sv
// Shared constants and types for the byte-enable dual-port RAM.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dpram_pkg;

    // Same-port read-during-write behaviour
    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;

    // Post-reset clear sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_READY = 2'd2
    } clr_state_t;

    // Number of byte lanes in a word
    function automatic int byte_count(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/dpram_rd_pipe.sv
// Per-port read output stage: registers read data and VALID, optional second register.
// Latency: 1 cycle (OUT_REG=0) or 2 cycles (OUT_REG=1) from accepted access.
// Backpressure: none; data holds its last value on cycles without an accepted access.
module dpram_rd_pipe #(
    parameter int DATA    = 32,
    parameter int OUT_REG = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            acc,
    input  logic [DATA-1:0] rdata,
    output logic [DATA-1:0] dout,
    output logic            valid
);

    logic [DATA-1:0] d1;
    logic            v1;

    // First stage: capture read data only on accepted accesses so the output holds when idle
    always_ff @(posedge clk) begin
        if (rst) begin
            d1 <= '0;
            v1 <= 1'b0;
        end else begin
            v1 <= acc;
            if (acc) begin
                d1 <= rdata;
            end
        end
    end

    if (OUT_REG != 0) begin : g_oreg
        logic [DATA-1:0] d2;
        logic            v2;

        // Second stage: follows the first stage, again holding on bubbles
        always_ff @(posedge clk) begin
            if (rst) begin
                d2 <= '0;
                v2 <= 1'b0;
            end else begin
                v2 <= v1;
                if (v1) begin
                    d2 <= d1;
                end
            end
        end

        assign dout  = d2;
        assign valid = v2;
    end else begin : g_noreg
        assign dout  = d1;
        assign valid = v1;
    end

endmodule

// File: rtl/dpram_be_clr.sv
// True dual-port RAM with byte enables, RDW mode, A-wins collision merge and post-reset clear sweep.
// Latency: read data 1+OUT_REG cycles after the accepted access; coll_ERR 1 cycle.
// Backpressure: none; requests while init_BUSY or rsT is high are silently dropped.
module dpram_be_clr
    import dpram_pkg::*;
#(
    parameter int              DATA           = 32,
    parameter int              ADDR           = 10,
    parameter int              OUT_REG        = 0,
    parameter int              RDW_MODE       = 0,
    parameter int              CLEAR_ON_RESET = 1,
    parameter logic [DATA-1:0] INIT_VAL       = '0
) (
    input  logic                clK,
    input  logic                rsT,
    output logic                init_BUSY,

    input  logic                a_port_EN,
    input  logic                a_port_WR,
    input  logic [DATA/8-1:0]   a_port_BE,
    input  logic [ADDR-1:0]     a_port_ADDR,
    input  logic [DATA-1:0]     a_port_data_IN,
    output logic [DATA-1:0]     a_port_data_OUT,
    output logic                a_port_VALID,

    input  logic                b_port_EN,
    input  logic                b_port_WR,
    input  logic [DATA/8-1:0]   b_port_BE,
    input  logic [ADDR-1:0]     b_port_ADDR,
    input  logic [DATA-1:0]     b_port_data_IN,
    output logic [DATA-1:0]     b_port_data_OUT,
    output logic                b_port_VALID,

    output logic                coll_ERR
);

    localparam int NB    = byte_count(DATA);
    localparam int DEPTH = 1 << ADDR;

    logic [DATA-1:0] mem [DEPTH];

    clr_state_t      state;
    logic [ADDR-1:0] cnt;
    logic            busy_q;
    logic            clr_we;

    logic            a_acc, b_acc;
    logic [NB-1:0]   a_we, b_we;
    logic [DATA-1:0] a_old, b_old, a_merge, b_merge, a_rd, b_rd;
    logic            coll_q;

    // The sweep writes one word per cycle starting on the reset-release edge, so it
    // spans exactly DEPTH cycles; busy is registered and so covers the reset cycle too.
    assign clr_we    = (CLEAR_ON_RESET != 0) && !rsT &&
                       ((state == ST_IDLE) || (state == ST_CLEAR));
    assign init_BUSY = busy_q;

    // Clear sequencer: IDLE on reset, sweep all addresses, then READY
    always_ff @(posedge clK) begin
        if (rsT) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            busy_q <= (CLEAR_ON_RESET != 0);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (CLEAR_ON_RESET != 0) begin
                        state <= ST_CLEAR;
                        cnt   <= cnt + 1'b1;
                    end else begin
                        state <= ST_READY;
                    end
                end
                ST_CLEAR: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == '1) begin
                        state  <= ST_READY;
                        busy_q <= 1'b0;
                    end
                end
                ST_READY: begin
                    state <= ST_READY;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // A request counts only when the memory is not sweeping and not being reset
    assign a_acc = a_port_EN && !busy_q && !rsT;
    assign b_acc = b_port_EN && !busy_q && !rsT;
    assign a_we  = {NB{a_acc && a_port_WR}} & a_port_BE;
    assign b_we  = {NB{b_acc && b_port_WR}} & b_port_BE;

    // Memory writes: port B lanes first, port A lanes after, so A wins overlapping bytes
    always_ff @(posedge clK) begin
        if (clr_we) begin
            mem[cnt] <= INIT_VAL;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (b_we[i]) begin
                    mem[b_port_ADDR][i*8 +: 8] <= b_port_data_IN[i*8 +: 8];
                end
            end
            for (int i = 0; i < NB; i++) begin
                if (a_we[i]) begin
                    mem[a_port_ADDR][i*8 +: 8] <= a_port_data_IN[i*8 +: 8];
                end
            end
        end
    end

    // Read data: old word, or the old word merged with this port's own write lanes.
    // The other port's write is never forwarded, so cross-port reads always see old data.
    always_comb begin
        a_old   = mem[a_port_ADDR];
        b_old   = mem[b_port_ADDR];
        a_merge = a_old;
        b_merge = b_old;
        for (int i = 0; i < NB; i++) begin
            if (a_we[i]) a_merge[i*8 +: 8] = a_port_data_IN[i*8 +: 8];
            if (b_we[i]) b_merge[i*8 +: 8] = b_port_data_IN[i*8 +: 8];
        end
        a_rd = (RDW_MODE == RDW_WRITE_FIRST) ? a_merge : a_old;
        b_rd = (RDW_MODE == RDW_WRITE_FIRST) ? b_merge : b_old;
    end

    // Collision flag: both ports wrote at least one common byte of the same word
    always_ff @(posedge clK) begin
        if (rsT) begin
            coll_q <= 1'b0;
        end else begin
            coll_q <= (a_port_ADDR == b_port_ADDR) && (|(a_we & b_we));
        end
    end

    assign coll_ERR = coll_q;

    dpram_rd_pipe #(
        .DATA    (DATA),
        .OUT_REG (OUT_REG)
    ) u_rd_a (
        .clk   (clK),
        .rst   (rsT),
        .acc   (a_acc),
        .rdata (a_rd),
        .dout  (a_port_data_OUT),
        .valid (a_port_VALID)
    );

    dpram_rd_pipe #(
        .DATA    (DATA),
        .OUT_REG (OUT_REG)
    ) u_rd_b (
        .clk   (clK),
        .rst   (rsT),
        .acc   (b_acc),
        .rdata (b_rd),
        .dout  (b_port_data_OUT),
        .valid (b_port_VALID)
    );

endmodule

// File: tb/tb_dpram_be_clr.sv
// Directed bench for dpram_be_clr: two instances share stimulus,
// u_rf (OUT_REG=0, READ_FIRST) and u_wf (OUT_REG=1, WRITE_FIRST).
// Expected values are hand-computed constants per scenario.
module tb_dpram_be_clr;

    logic        clk;
    logic        rst;
    logic        a_en, a_wr, b_en, b_wr;
    logic [3:0]  a_be, b_be, a_addr, b_addr;
    logic [31:0] a_din, b_din;

    logic        rf_busy, rf_a_vld, rf_b_vld, rf_coll;
    logic [31:0] rf_a_dout, rf_b_dout;
    logic        wf_busy, wf_a_vld, wf_b_vld, wf_coll;
    logic [31:0] wf_a_dout, wf_b_dout;

    int checks   = 0;
    int failures = 0;

    dpram_be_clr #(
        .DATA(32), .ADDR(4), .OUT_REG(0), .RDW_MODE(0),
        .CLEAR_ON_RESET(1), .INIT_VAL(32'hA5A5A5A5)
    ) u_rf (
        .clK(clk), .rsT(rst), .init_BUSY(rf_busy),
        .a_port_EN(a_en), .a_port_WR(a_wr), .a_port_BE(a_be), .a_port_ADDR(a_addr),
        .a_port_data_IN(a_din), .a_port_data_OUT(rf_a_dout), .a_port_VALID(rf_a_vld),
        .b_port_EN(b_en), .b_port_WR(b_wr), .b_port_BE(b_be), .b_port_ADDR(b_addr),
        .b_port_data_IN(b_din), .b_port_data_OUT(rf_b_dout), .b_port_VALID(rf_b_vld),
        .coll_ERR(rf_coll)
    );

    dpram_be_clr #(
        .DATA(32), .ADDR(4), .OUT_REG(1), .RDW_MODE(1),
        .CLEAR_ON_RESET(1), .INIT_VAL(32'hA5A5A5A5)
    ) u_wf (
        .clK(clk), .rsT(rst), .init_BUSY(wf_busy),
        .a_port_EN(a_en), .a_port_WR(a_wr), .a_port_BE(a_be), .a_port_ADDR(a_addr),
        .a_port_data_IN(a_din), .a_port_data_OUT(wf_a_dout), .a_port_VALID(wf_a_vld),
        .b_port_EN(b_en), .b_port_WR(b_wr), .b_port_BE(b_be), .b_port_ADDR(b_addr),
        .b_port_data_IN(b_din), .b_port_data_OUT(wf_b_dout), .b_port_VALID(wf_b_vld),
        .coll_ERR(wf_coll)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic drive_a(input logic en, input logic wr, input logic [3:0] be,
                           input logic [3:0] addr, input logic [31:0] din);
        a_en = en; a_wr = wr; a_be = be; a_addr = addr; a_din = din;
    endtask

    task automatic drive_b(input logic en, input logic wr, input logic [3:0] be,
                           input logic [3:0] addr, input logic [31:0] din);
        b_en = en; b_wr = wr; b_be = be; b_addr = addr; b_din = din;
    endtask

    task automatic idle();
        drive_a(1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
        drive_b(1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
    endtask

    // Reset values, busy length of exactly 16 cycles, requests dropped during reset and sweep
    task automatic test_reset();
        int n;
        rst = 1'b1;
        drive_a(1'b1, 1'b1, 4'hF, 4'h5, 32'h0);
        drive_b(1'b1, 1'b1, 4'hF, 4'h5, 32'h0);
        step();
        checks++; if (rf_busy !== 1'b1) begin failures++; $display("FAIL rst_busy got=%b exp=1", rf_busy); end
        checks++; if (rf_a_dout !== 32'h0 || rf_b_dout !== 32'h0) begin failures++; $display("FAIL rst_dout got=%h/%h exp=0", rf_a_dout, rf_b_dout); end
        checks++; if (rf_a_vld !== 1'b0 || rf_b_vld !== 1'b0) begin failures++; $display("FAIL rst_vld got=%b/%b exp=0", rf_a_vld, rf_b_vld); end
        checks++; if (rf_coll !== 1'b0 || wf_coll !== 1'b0) begin failures++; $display("FAIL rst_coll got=%b/%b exp=0", rf_coll, wf_coll); end
        checks++; if (wf_a_dout !== 32'h0 || wf_a_vld !== 1'b0) begin failures++; $display("FAIL rst_wf_out got=%h/%b exp=0/0", wf_a_dout, wf_a_vld); end
        rst = 1'b0;
        n = 0;
        while (rf_busy === 1'b1 && n < 100) begin
            n++;
            checks++;
            if (rf_a_vld !== 1'b0 || rf_b_vld !== 1'b0 || rf_coll !== 1'b0) begin
                failures++; $display("FAIL sweep_drop got=%b%b%b exp=000", rf_a_vld, rf_b_vld, rf_coll);
            end
            step();
        end
        checks++; if (n != 16) begin failures++; $display("FAIL busy_len got=%0d exp=16", n); end
        checks++; if (wf_busy !== 1'b0) begin failures++; $display("FAIL wf_busy_end got=%b exp=0", wf_busy); end
        idle();
    endtask

    // Every word holds INIT_VAL after the sweep; first access right after busy falls
    task automatic test_clear_reads();
        for (int i = 0; i <= 16; i++) begin
            if (i < 16) begin
                drive_a(1'b1, 1'b0, 4'h0, 4'(i), 32'h0);
                drive_b(1'b1, 1'b0, 4'h0, 4'(15 - i), 32'h0);
            end else begin
                idle();
            end
            step();
            if (i < 16) begin
                checks++;
                if (rf_a_vld !== 1'b1 || rf_a_dout !== 32'hA5A5A5A5) begin
                    failures++; $display("FAIL clr_rd_a[%0d] got=%b/%h exp=1/a5a5a5a5", i, rf_a_vld, rf_a_dout);
                end
                checks++;
                if (rf_b_vld !== 1'b1 || rf_b_dout !== 32'hA5A5A5A5) begin
                    failures++; $display("FAIL clr_rd_b[%0d] got=%b/%h exp=1/a5a5a5a5", i, rf_b_vld, rf_b_dout);
                end
            end else begin
                checks++;
                if (rf_a_vld !== 1'b0) begin failures++; $display("FAIL clr_rd_end_vld got=%b exp=0", rf_a_vld); end
            end
            if (i >= 1) begin
                checks++;
                if (wf_a_vld !== 1'b1 || wf_a_dout !== 32'hA5A5A5A5) begin
                    failures++; $display("FAIL clr_rd_l2[%0d] got=%b/%h exp=1/a5a5a5a5", i, wf_a_vld, wf_a_dout);
                end
            end
        end
    endtask

    // Partial byte write, next-cycle read on the other port, output hold on idle
    task automatic test_byte_write();
        drive_a(1'b1, 1'b1, 4'b0101, 4'd3, 32'h11223344);
        drive_b(1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
        step();
        checks++; if (rf_a_vld !== 1'b1 || rf_a_dout !== 32'hA5A5A5A5) begin failures++; $display("FAIL bw_rdfirst got=%b/%h exp=1/a5a5a5a5", rf_a_vld, rf_a_dout); end
        drive_a(1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
        drive_b(1'b1, 1'b0, 4'h0, 4'd3, 32'h0);
        step();
        checks++; if (rf_b_vld !== 1'b1 || rf_b_dout !== 32'hA522A544) begin failures++; $display("FAIL bw_read_b got=%b/%h exp=1/a522a544", rf_b_vld, rf_b_dout); end
        checks++; if (wf_a_vld !== 1'b1 || wf_a_dout !== 32'hA522A544) begin failures++; $display("FAIL bw_wrfirst_l2 got=%b/%h exp=1/a522a544", wf_a_vld, wf_a_dout); end
        idle();
        step();
        checks++; if (rf_b_vld !== 1'b0 || rf_b_dout !== 32'hA522A544) begin failures++; $display("FAIL bw_hold got=%b/%h exp=0/a522a544", rf_b_vld, rf_b_dout); end
        checks++; if (wf_b_vld !== 1'b1 || wf_b_dout !== 32'hA522A544) begin failures++; $display("FAIL bw_read_b_l2 got=%b/%h exp=1/a522a544", wf_b_vld, wf_b_dout); end
    endtask

    // Same-address dual write merge, collision pulse, and non-colliding cases
    task automatic test_collision();
        drive_a(1'b1, 1'b1, 4'b0011, 4'd7, 32'hAAAAAAAA);
        drive_b(1'b1, 1'b1, 4'b0110, 4'd7, 32'hBBBBBBBB);
        step();
        checks++; if (rf_coll !== 1'b1 || wf_coll !== 1'b1) begin failures++; $display("FAIL coll_pulse got=%b/%b exp=1/1", rf_coll, wf_coll); end
        checks++; if (rf_a_dout !== 32'hA5A5A5A5 || rf_b_dout !== 32'hA5A5A5A5) begin failures++; $display("FAIL coll_old got=%h/%h exp=a5a5a5a5", rf_a_dout, rf_b_dout); end
        drive_a(1'b1, 1'b0, 4'h0, 4'd7, 32'h0);
        drive_b(1'b1, 1'b0, 4'h0, 4'd7, 32'h0);
        step();
        checks++; if (rf_coll !== 1'b0) begin failures++; $display("FAIL coll_once got=%b exp=0", rf_coll); end
        checks++; if (rf_a_dout !== 32'hA5BBAAAA || rf_b_dout !== 32'hA5BBAAAA) begin failures++; $display("FAIL coll_merge got=%h/%h exp=a5bbaaaa", rf_a_dout, rf_b_dout); end
        drive_a(1'b1, 1'b1, 4'b0001, 4'd8, 32'hAAAAAAAA);
        drive_b(1'b1, 1'b1, 4'b0010, 4'd8, 32'hBBBBBBBB);
        step();
        checks++; if (rf_coll !== 1'b0) begin failures++; $display("FAIL coll_disjoint got=%b exp=0", rf_coll); end
        drive_a(1'b1, 1'b1, 4'b1000, 4'd9, 32'h11111111);
        drive_b(1'b1, 1'b1, 4'b1000, 4'd10, 32'h22222222);
        step();
        checks++; if (rf_coll !== 1'b0) begin failures++; $display("FAIL coll_diffaddr got=%b exp=0", rf_coll); end
        drive_a(1'b1, 1'b0, 4'h0, 4'd8, 32'h0);
        drive_b(1'b1, 1'b0, 4'h0, 4'd9, 32'h0);
        step();
        checks++; if (rf_a_dout !== 32'hA5A5BBAA) begin failures++; $display("FAIL disjoint_word got=%h exp=a5a5bbaa", rf_a_dout); end
        checks++; if (rf_b_dout !== 32'h11A5A5A5) begin failures++; $display("FAIL addr9_word got=%h exp=11a5a5a5", rf_b_dout); end
        drive_a(1'b1, 1'b0, 4'h0, 4'd10, 32'h0);
        drive_b(1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
        step();
        checks++; if (rf_a_dout !== 32'h22A5A5A5) begin failures++; $display("FAIL addr10_word got=%h exp=22a5a5a5", rf_a_dout); end
        idle();
    endtask

    // Same-port read-during-write per mode, cross-port read sees old data, latency 2
    task automatic test_rdw();
        drive_a(1'b1, 1'b1, 4'hF, 4'd2, 32'h00000000);
        step();
        drive_a(1'b1, 1'b1, 4'hF, 4'd2, 32'h000000FF);
        drive_b(1'b1, 1'b0, 4'h0, 4'd2, 32'h0);
        step();
        checks++; if (rf_a_vld !== 1'b1 || rf_a_dout !== 32'h0) begin failures++; $display("FAIL rdw_rdfirst got=%b/%h exp=1/00000000", rf_a_vld, rf_a_dout); end
        checks++; if (rf_b_dout !== 32'h0) begin failures++; $display("FAIL rdw_xport_rf got=%h exp=00000000", rf_b_dout); end
        checks++; if (wf_a_vld !== 1'b1 || wf_a_dout !== 32'h0) begin failures++; $display("FAIL rdw_wf_prev got=%b/%h exp=1/00000000", wf_a_vld, wf_a_dout); end
        idle();
        step();
        checks++; if (wf_a_vld !== 1'b1 || wf_a_dout !== 32'h000000FF) begin failures++; $display("FAIL rdw_wrfirst got=%b/%h exp=1/000000ff", wf_a_vld, wf_a_dout); end
        checks++; if (wf_b_vld !== 1'b1 || wf_b_dout !== 32'h0) begin failures++; $display("FAIL rdw_xport_wf got=%b/%h exp=1/00000000", wf_b_vld, wf_b_dout); end
        checks++; if (rf_a_vld !== 1'b0 || rf_a_dout !== 32'h0) begin failures++; $display("FAIL rdw_hold got=%b/%h exp=0/00000000", rf_a_vld, rf_a_dout); end
        step();
        checks++; if (wf_a_vld !== 1'b0 || wf_a_dout !== 32'h000000FF) begin failures++; $display("FAIL rdw_wf_hold got=%b/%h exp=0/000000ff", wf_a_vld, wf_a_dout); end
    endtask

    // Reset at cnt=9 restarts the sweep; stale writes during the sweep are dropped
    task automatic test_reset_mid_sweep();
        int n;
        drive_a(1'b1, 1'b1, 4'hF, 4'd12, 32'h12345678);
        step();
        drive_a(1'b1, 1'b0, 4'h0, 4'd3, 32'h0);
        step();
        checks++; if (rf_a_dout !== 32'hA522A544) begin failures++; $display("FAIL pre_rst_read got=%h exp=a522a544", rf_a_dout); end
        idle();
        rst = 1'b1;
        step();
        checks++; if (rf_a_dout !== 32'h0 || rf_busy !== 1'b1) begin failures++; $display("FAIL rst2_state got=%h/%b exp=00000000/1", rf_a_dout, rf_busy); end
        rst = 1'b0;
        drive_a(1'b1, 1'b1, 4'hF, 4'd12, 32'hDEADBEEF);
        drive_b(1'b1, 1'b1, 4'hF, 4'd9, 32'hDEADBEEF);
        for (int i = 0; i < 9; i++) begin
            step();
            checks++;
            if (rf_a_vld !== 1'b0 || rf_busy !== 1'b1) begin failures++; $display("FAIL sweep1[%0d] got=%b/%b exp=0/1", i, rf_a_vld, rf_busy); end
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n = 0;
        while (rf_busy === 1'b1 && n < 100) begin
            n++;
            checks++;
            if (rf_a_vld !== 1'b0 || rf_b_vld !== 1'b0) begin failures++; $display("FAIL sweep2_drop got=%b/%b exp=0/0", rf_a_vld, rf_b_vld); end
            step();
        end
        checks++; if (n != 16) begin failures++; $display("FAIL busy_len2 got=%0d exp=16", n); end
        drive_a(1'b1, 1'b0, 4'h0, 4'd12, 32'h0);
        drive_b(1'b1, 1'b0, 4'h0, 4'd9, 32'h0);
        step();
        checks++; if (rf_a_dout !== 32'hA5A5A5A5 || rf_b_dout !== 32'hA5A5A5A5) begin failures++; $display("FAIL resweep_12_9 got=%h/%h exp=a5a5a5a5", rf_a_dout, rf_b_dout); end
        drive_a(1'b1, 1'b0, 4'h0, 4'd3, 32'h0);
        drive_b(1'b1, 1'b0, 4'h0, 4'd15, 32'h0);
        step();
        checks++; if (rf_a_dout !== 32'hA5A5A5A5 || rf_b_dout !== 32'hA5A5A5A5) begin failures++; $display("FAIL resweep_3_15 got=%h/%h exp=a5a5a5a5", rf_a_dout, rf_b_dout); end
        idle();
        step();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_clear_reads();
        test_byte_write();
        test_collision();
        test_rdw();
        test_reset_mid_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dpram_be_clr.md
# dpram_be_clr

Parametrised true dual-port RAM, successor to the basic two-port memory used under the FIFO blocks. It adds per-byte write enables, per-port enables, a selectable read-during-write mode, an optional output register and a deterministic cross-port write-collision policy. It also has an optional post-reset clear sequencer that sweeps every word to a known value. It serves as the storage core of the next-generation FIFO and as a general shared buffer between two single-clock agents.

## Interface
- DATA, 32, word width in bits; multiple of 8.
- ADDR, 10, address width; depth = 2**ADDR.
- OUT_REG, 0, 0: read latency 1; 1: extra output register, latency 2.
- RDW_MODE, 0, same-port read-during-write: 0 READ_FIRST (old data), 1 WRITE_FIRST (new merged data).
- CLEAR_ON_RESET, 1, 1: clear sweep after reset; 0: contents untouched by reset.
- INIT_VAL, 0, DATA-wide value written by the clear sweep.

Ports:
- clK  in  1  clock; all logic on rising edge.
- rsT  in  1  synchronous, active-high reset.
- init_BUSY  out  1  high while the clear sweep runs; port requests are ignored.
- a_port_EN  in  1  port A access enable.
- a_port_WR  in  1  port A write (qualified by EN).
- a_port_BE  in  DATA/8  port A byte enables for writes.
- a_port_ADDR  in  ADDR  port A address.
- a_port_data_IN  in  DATA  port A write data.
- a_port_data_OUT  out  DATA  port A read data.
- a_port_VALID  out  1  a_port_data_OUT carries the result of an accepted access.
- b_port_EN, b_port_WR, b_port_BE, b_port_ADDR, b_port_data_IN, b_port_data_OUT, b_port_VALID: same as port A, for port B.
- coll_ERR  out  1  one-cycle pulse: both ports wrote overlapping bytes of one address.

## Operation
- Reset (rsT high) zeroes all outputs (data_OUT, VALID, coll_ERR) and all pipeline stages. init_BUSY goes to 1 on the cycle after reset if CLEAR_ON_RESET=1, otherwise 0.
- Clear FSM states: IDLE, CLEAR, READY.
  - IDLE→CLEAR on reset release when CLEAR_ON_RESET=1; IDLE→READY otherwise.
  - CLEAR writes INIT_VAL to address cnt, cnt = 0 … 2**ADDR−1, one word per cycle.
  - Last write → READY; init_BUSY drops the same cycle READY is entered.
  - rsT asserted in any state → IDLE; cnt = 0; sweep restarts from address 0.
- In READY, EN=1 is an accepted access. WR=1 writes the bytes with BE[i]=1; BE all-zero with WR=1 acts as a read with no write. EN=0 means no access.
- Every accepted access (read or write) produces read data. Same-address read-during-write follows RDW_MODE.
- Cross-port, same address, both writing:
  - Bytes enabled on both ports take port A data.
  - Bytes enabled on one port only take that port's data.
  - coll_ERR pulses one cycle later if any byte overlapped.
- Cross-port read while the other port writes the same address: the reader sees old data, whatever RDW_MODE is.
- data_OUT holds its last value while no access is accepted. VALID is low on those cycles.

## Timing
- Read latency is 1+OUT_REG cycles from the accepted access edge to data_OUT/VALID. Fully pipelined: one access per port per cycle.
- A write is visible to a read on either port issued on the following cycle.
- The clear sweep takes exactly 2**ADDR cycles. The first accepted access is on the cycle after init_BUSY falls.
- Requests made while init_BUSY=1 are dropped with no write and no VALID. This includes requests in the reset cycle.
- coll_ERR is registered with latency 1, independent of OUT_REG.

## Structure
- Package dpram_pkg holds:
  - RDW_READ_FIRST / RDW_WRITE_FIRST constants.
  - Clear FSM state enum (IDLE, CLEAR, READY).
  - Byte-count helper DATA/8.
- Sub-module dpram_rd_pipe: per-port output stage (optional OUT_REG register, VALID pipeline, hold-on-idle, reset). Instantiated once per port.
- Top level holds the memory array, byte-merge and collision logic, and the clear FSM.

## Test plan
- Reset with ADDR=4, INIT_VAL=0xA5A5A5A5 → init_BUSY high for exactly 16 cycles. Reads of addresses 0–15 then return 0xA5A5A5A5 with VALID after 1 cycle (OUT_REG=0).
- A writes 0x11223344 BE=0b0101 to addr 3 over 0xA5A5A5A5 → next-cycle read on B returns 0xA522A544.
- Same cycle, A writes 0xAAAAAAAA BE=0b0011 and B writes 0xBBBBBBBB BE=0b0110 to addr 7 → word 0xA5BBAAAA; coll_ERR pulses once.
- Same-port write+read of addr 2 (old 0x0, new 0xFF) → RDW_MODE=0 returns 0x0; RDW_MODE=1 returns 0xFF. With OUT_REG=1, data appears at latency 2.
- rsT pulsed mid-sweep at cnt=9 → sweep restarts at 0; init_BUSY is high for 16 further cycles; requests during sweep produce no VALID and no write.
